// File: rtl/rom_stream_reader.sv
// Read initiator for a 1-cycle synchronous ROM: fetches a run of words and streams
// them out through a credit-limited FIFO so back-pressure never drops a returned word.
module rom_stream_reader #(
    parameter int unsigned AW         = 4,
    parameter int unsigned DW         = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rom_en_o,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   issued_q, issued_d;
    logic [AW:0]   popped_q, popped_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pend_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic          push, pop, credit_ok;

    // Credit counts words already in the FIFO plus the read still in flight; the
    // same-cycle pop is deliberately ignored so out_ready never reaches rom_en.
    assign credit_ok = ({1'b0, count_q} + (CW+1)'(pend_q)) < (CW+1)'(FIFO_DEPTH);

    assign rom_en_o    = (state_q == StRun) && (issued_q < len_q) && credit_ok;
    assign rom_addr_o  = addr_q;
    assign busy_o      = (state_q == StRun) || (state_q == StDone);
    assign done_o      = (state_q == StDone);
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign out_last_o  = out_valid_o && (popped_q == len_q - 1'b1);

    assign push = pend_q;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = popped_q;
        addr_d   = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d    = len_i;
                    issued_d = '0;
                    popped_d = '0;
                    addr_d   = base_addr_i;
                    state_d  = (len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rom_en_o) begin
                    issued_d = issued_q + 1'b1;
                    addr_d   = addr_q + 1'b1;
                end
                if (pop) begin
                    popped_d = popped_q + 1'b1;
                    if (out_last_o) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            addr_q   <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            addr_q   <= addr_d;
            pend_q   <= rom_en_o;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: out_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rom_data_i;
    end

endmodule
